// File: rtl/frontend_pkg.sv
// Shared frontend definitions: word layout constants and the time-tag word builder.
package frontend_pkg;

    localparam logic [3:0] TT_HDR   = 4'hF;
    localparam int         WORD_W   = 64;
    localparam int         PERIOD_W = 48;
    localparam int         CH_IDX_W = 3;

    // Time-tag word: reserved header, zero padding, then the 48-bit period count.
    function automatic logic [WORD_W-1:0] make_tt_word(input logic [PERIOD_W-1:0] p_cnt);
        return {TT_HDR, {(WORD_W-4-PERIOD_W){1'b0}}, p_cnt};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after rr_ptr wins; the pointer
// moves one past the winner only when the caller confirms the grant was used.
module rr_arbiter #(
    parameter  int NCH   = 4,
    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    input  logic             advance,
    output logic [NCH-1:0]   grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any_req
);

    logic [PTR_W-1:0] rr_ptr;

    // Scan requesters starting at rr_ptr, wrapping modulo NCH, and pick the first.
    always_comb begin : p_scan
        int idx;
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = 0;
        for (int off = 0; off < NCH; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!any_req && req[idx]) begin
                any_req    = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

    // Move the pointer one past the channel that was actually served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (grant_idx == PTR_W'(NCH-1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/timetag_link_arbiter.sv
// Merges NCH channel event streams and the 1 ms time-tag onto one registered
// output link. A pending time-tag always wins the next free slot; otherwise
// channels are served round-robin while en is high.
module timetag_link_arbiter
    import frontend_pkg::*;
#(
    parameter  int NCH    = 4,
    parameter  int PAY_W  = 60,
    parameter  int MISS_W = 16,
    localparam int OUT_W  = 4 + PAY_W,
    localparam int PTR_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   period_done,
    input  logic [PERIOD_W-1:0]    period,
    input  logic [NCH-1:0]         ch_valid,
    input  logic [NCH*PAY_W-1:0]   ch_data,
    output logic [NCH-1:0]         ch_ready,
    output logic                   out_valid,
    output logic [OUT_W-1:0]       out_data,
    input  logic                   out_ready,
    output logic [MISS_W-1:0]      tt_missed
);

    logic                slot_free;
    logic                tt_pend;
    logic [PERIOD_W-1:0] tt_val;
    logic                tt_consume;
    logic                ch_advance;
    logic [NCH-1:0]      rr_grant;
    logic [PTR_W-1:0]    rr_idx;
    logic                rr_any;
    logic [PAY_W-1:0]    sel_pay;
    logic [OUT_W-1:0]    ch_word;
    logic [OUT_W-1:0]    tt_word;

    assign slot_free  = !out_valid || out_ready;
    assign tt_consume = slot_free && tt_pend;
    // A channel is served only when the slot is free and no time-tag is waiting.
    assign ch_advance = slot_free && !tt_pend && rr_any;
    assign ch_ready   = (ch_advance && !rst) ? rr_grant : '0;

    rr_arbiter #(
        .NCH (NCH)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (ch_valid & {NCH{en}}),
        .advance   (ch_advance),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any_req   (rr_any)
    );

    assign sel_pay = ch_data[int'(rr_idx)*PAY_W +: PAY_W];
    assign ch_word = {1'b0, CH_IDX_W'(rr_idx), sel_pay};

    generate
        if (OUT_W == WORD_W) begin : g_tt_std
            assign tt_word = make_tt_word(tt_val);
        end else begin : g_tt_gen
            assign tt_word = {TT_HDR, PAY_W'(tt_val)};
        end
    endgenerate

    // Stage 0 -> 1: latch each period boundary; count tags overwritten before they were sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt_pend   <= 1'b0;
            tt_val    <= '0;
            tt_missed <= '0;
        end else if (period_done) begin
            tt_val  <= period;
            tt_pend <= 1'b1;
            if (tt_pend && !tt_consume && (tt_missed != '1)) begin
                tt_missed <= tt_missed + 1'b1;
            end
        end else if (tt_consume) begin
            tt_pend <= 1'b0;
        end
    end

    // Stage 1 -> 2: output word register, loaded only when the downstream slot is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (slot_free) begin
            if (tt_pend) begin
                out_data  <= tt_word;
                out_valid <= 1'b1;
            end else if (ch_advance) begin
                out_data  <= ch_word;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_timetag_link_arbiter.sv
// Directed bench for timetag_link_arbiter: a per-cycle vector table plus
// hand-written sequences for asynchronous reset and miss-counter saturation.
module tb_timetag_link_arbiter;

    localparam int NCH   = 4;
    localparam int PAY_W = 60;

    localparam logic [63:0] W0 = 64'h0111_1111_1111_1111;
    localparam logic [63:0] W1 = 64'h1222_2222_2222_2222;
    localparam logic [63:0] W2 = 64'h2333_3333_3333_3333;
    localparam logic [63:0] W3 = 64'h3444_4444_4444_4444;
    localparam logic [63:0] TT = 64'hF000_0000_0000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              period_done;
    logic [47:0]       period;
    logic [NCH-1:0]    ch_valid;
    logic [NCH*PAY_W-1:0] ch_data;
    logic [NCH-1:0]    ch_ready;
    logic              out_valid;
    logic [63:0]       out_data;
    logic              out_ready;
    logic [15:0]       tt_missed;

    logic              s_en;
    logic              s_pd;
    logic [47:0]       s_per;
    logic [NCH-1:0]    s_cv;
    logic [NCH-1:0]    s_rdy;
    logic              s_ov;
    logic [63:0]       s_od;
    logic              s_ordy;
    logic [1:0]        s_miss;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    timetag_link_arbiter #(.NCH(NCH), .PAY_W(PAY_W), .MISS_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .period_done (period_done),
        .period      (period),
        .ch_valid    (ch_valid),
        .ch_data     (ch_data),
        .ch_ready    (ch_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .tt_missed   (tt_missed)
    );

    // Narrow miss counter so saturation is reachable in a handful of cycles.
    timetag_link_arbiter #(.NCH(NCH), .PAY_W(PAY_W), .MISS_W(2)) dut_s (
        .clk         (clk),
        .rst         (rst),
        .en          (s_en),
        .period_done (s_pd),
        .period      (s_per),
        .ch_valid    (s_cv),
        .ch_data     (ch_data),
        .ch_ready    (s_rdy),
        .out_valid   (s_ov),
        .out_data    (s_od),
        .out_ready   (s_ordy),
        .tt_missed   (s_miss)
    );

    typedef struct {
        logic           en;
        logic [3:0]     cv;
        logic           ordy;
        logic           pd;
        logic [47:0]    per;
        logic [3:0]     x_rdy;
        logic           x_ov;
        logic [63:0]    x_od;
        logic [15:0]    x_miss;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic [3:0] cv, input logic ordy, input logic pd,
                       input logic [47:0] per, input logic [3:0] x_rdy, input logic x_ov,
                       input logic [63:0] x_od, input logic [15:0] x_miss);
        vec_t v;
        v.en = e; v.cv = cv; v.ordy = ordy; v.pd = pd; v.per = per;
        v.x_rdy = x_rdy; v.x_ov = x_ov; v.x_od = x_od; v.x_miss = x_miss;
        vt.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_s[6];
        logic [59:0] pay;
        exp_s = '{0, 0, 1, 2, 3, 3};
        pay = 60'h111_1111_1111_1111;
        for (int i = 0; i < NCH; i++) begin
            ch_data[i*PAY_W +: PAY_W] = pay * 60'(i + 1);
        end

        rst = 1'b1; en = 1'b0; period_done = 1'b0; period = '0;
        ch_valid = '0; out_ready = 1'b0;
        s_en = 1'b0; s_pd = 1'b0; s_per = '0; s_cv = '0; s_ordy = 1'b0;

        // Columns: en, ch_valid, out_ready, period_done, period | ch_ready, out_valid, out_data, tt_missed
        // Round-robin over ch0/ch2
        add(1, 4'b0101, 1, 0, 48'h0,       4'b0001, 0, 64'h0, 0);
        add(1, 4'b0101, 1, 0, 48'h0,       4'b0100, 1, W0,    0);
        add(1, 4'b0101, 1, 0, 48'h0,       4'b0001, 1, W2,    0);
        add(1, 4'b0101, 1, 0, 48'h0,       4'b0100, 1, W0,    0);
        // Time-tag inserted into a ch0 stream
        add(1, 4'b0001, 1, 1, 48'h1_2345,  4'b0001, 1, W2,    0);
        add(1, 4'b0001, 1, 0, 48'h0,       4'b0000, 1, W0,    0);
        add(1, 4'b0001, 1, 0, 48'h0,       4'b0001, 1, TT | 64'h1_2345, 0);
        add(1, 4'b0000, 1, 0, 48'h0,       4'b0000, 1, W0,    0);
        add(1, 4'b0000, 1, 0, 48'h0,       4'b0000, 0, W0,    0);
        // en=0: only the time-tag gets through
        add(0, 4'b1111, 1, 1, 48'h7,       4'b0000, 0, W0,    0);
        add(0, 4'b1111, 1, 0, 48'h0,       4'b0000, 0, W0,    0);
        add(0, 4'b1111, 1, 0, 48'h0,       4'b0000, 1, TT | 64'h7, 0);
        add(0, 4'b1111, 1, 0, 48'h0,       4'b0000, 0, TT | 64'h7, 0);
        add(1, 4'b1111, 1, 0, 48'h0,       4'b0010, 0, TT | 64'h7, 0);
        // Backpressure for 10 cycles, two period pulses
        add(1, 4'b1111, 0, 0, 48'h0,       4'b0000, 1, W1,    0);
        add(1, 4'b1111, 0, 1, 48'h5,       4'b0000, 1, W1,    0);
        add(1, 4'b1111, 0, 0, 48'h0,       4'b0000, 1, W1,    0);
        add(1, 4'b1111, 0, 1, 48'h6,       4'b0000, 1, W1,    0);
        for (int k = 0; k < 6; k++) begin
            add(1, 4'b1111, 0, 0, 48'h0,   4'b0000, 1, W1,    1);
        end
        add(1, 4'b1111, 1, 0, 48'h0,       4'b0000, 1, W1,    1);
        add(1, 4'b1111, 1, 0, 48'h0,       4'b0100, 1, TT | 64'h6, 1);
        add(1, 4'b1111, 1, 0, 48'h0,       4'b1000, 1, W2,    1);
        // Pulse coinciding with consumption of the pending tag
        add(1, 4'b1111, 1, 1, 48'h8,       4'b0001, 1, W3,    1);
        add(1, 4'b1111, 1, 1, 48'h9,       4'b0000, 1, W0,    1);
        add(1, 4'b1111, 1, 0, 48'h0,       4'b0000, 1, TT | 64'h8, 1);
        add(1, 4'b1111, 1, 0, 48'h0,       4'b0010, 1, TT | 64'h9, 1);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset out_valid", 64'(out_valid), 64'h0);
        chk("reset out_data",  out_data,       64'h0);
        chk("reset ch_ready",  64'(ch_ready),  64'h0);
        chk("reset tt_missed", 64'(tt_missed), 64'h0);

        foreach (vt[i]) begin
            @(posedge clk);
            #1;
            en = vt[i].en; ch_valid = vt[i].cv; out_ready = vt[i].ordy;
            period_done = vt[i].pd; period = vt[i].per;
            @(negedge clk);
            chk($sformatf("v%0d ch_ready", i),  64'(ch_ready),  64'(vt[i].x_rdy));
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vt[i].x_ov));
            chk($sformatf("v%0d out_data", i),  out_data,       vt[i].x_od);
            chk($sformatf("v%0d tt_missed", i), 64'(tt_missed), 64'(vt[i].x_miss));
        end

        // Asynchronous reset while a word is held and a tag is pending
        @(posedge clk);
        #1;
        en = 1'b1; ch_valid = '0; out_ready = 1'b0; period_done = 1'b1; period = 48'hA;
        @(posedge clk);
        #1 period_done = 1'b0;
        @(negedge clk);
        chk("pre-rst out_valid", 64'(out_valid),   64'h1);
        chk("pre-rst tt_pend",   64'(dut.tt_pend), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("async out_valid", 64'(out_valid),         64'h0);
        chk("async out_data",  out_data,               64'h0);
        chk("async tt_pend",   64'(dut.tt_pend),       64'h0);
        chk("async tt_val",    64'(dut.tt_val),        64'h0);
        chk("async rr_ptr",    64'(dut.u_rr.rr_ptr),   64'h0);
        chk("async tt_missed", 64'(tt_missed),         64'h0);
        chk("async ch_ready",  64'(ch_ready),          64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; en = 1'b1; ch_valid = 4'b1111; out_ready = 1'b1;
        @(negedge clk);
        chk("post-rst grant", 64'(ch_ready), 64'h1);
        @(posedge clk);
        #1 ch_valid = '0;

        // Saturation of the narrow miss counter
        s_en = 1'b1; s_cv = 4'b0001; s_ordy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            s_cv = '0; s_pd = 1'b1; s_per = 48'(k + 1);
            @(negedge clk);
            chk($sformatf("sat step%0d tt_missed", k), 64'(s_miss), 64'(exp_s[k]));
        end
        @(posedge clk);
        #1 s_pd = 1'b0;
        @(negedge clk);
        chk("sat hold tt_missed", 64'(s_miss), 64'h3);
        chk("sat hold out_data",  s_od,        W0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
